ws2812_serializer: RTL
======================

WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 SHALL have parameter T0H, default 8, meaning high-phase cycles for a 0 bit (0.4 us at 20 MHz).
REQ-002 SHALL have parameter T1H, default 16, meaning high-phase cycles for a 1 bit (0.8 us).
REQ-003 SHALL have parameter TBIT, default 25, meaning total cycles per bit (1.25 us).
REQ-004 SHALL have parameter TRESET, default 1000, meaning low cycles for the strip latch (50 us).
REQ-005 SHALL have one clock and an asynchronous active-low reset; no other clock or reset exists.
REQ-006 SHALL have port clk, input, 1, system clock (20 MHz).
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in, input, 24, colour word to send, sent bit 23 first, unmodified.
REQ-009 SHALL have port valid, input, 1, data_in/latch offered.
REQ-010 SHALL have port latch, input, 1, word is last of frame; strip reset follows it.
REQ-011 SHALL have port ready, output, 1, serializer idle and able to accept.
REQ-012 SHALL have port led, output, 1, registered serial line to the strip.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse at end of the latch period.

Function
REQ-014 SHALL implement states IDLE, HIGH, LOW, LATCH; ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a word on a rising edge where valid=1 and ready=1; data_in and latch SHALL be captured into internal registers on that edge.
REQ-016 On acceptance, SHALL go to HIGH with bit index 0, ready=0, and led=1 from the next cycle.
REQ-017 valid while ready=0 SHALL be ignored; no data is captured and state is unaffected.
REQ-018 In HIGH, led SHALL stay 1 for exactly T1H cycles if the current bit is 1, or T0H cycles if it is 0, then go to LOW.
REQ-019 In LOW, led SHALL stay 0 until the bit totals TBIT cycles.
REQ-020 After LOW, SHALL advance to the next bit and return to HIGH, for bits 23 down to 0.
REQ-021 One word SHALL occupy exactly 24*TBIT cycles of led activity (600 with defaults).
REQ-022 After bit 0 LOW, if latch was captured, SHALL enter LATCH with led=0 for TRESET cycles.
REQ-023 On LATCH exit, SHALL go to IDLE, set ready=1, and pulse frame_done for exactly one cycle.
REQ-024 After bit 0 LOW with latch not captured, SHALL go directly to IDLE with ready=1 on the first cycle after the 24*TBIT window.
REQ-025 Idle gaps between words SHALL hold led=0; an upstream refill of up to 4 cycles lengthens only the last bit's low time, which is acceptable.
REQ-026 Cycle counter width SHALL be $clog2(max(TBIT, TRESET))+1 bits, and the bit index 5 bits.
REQ-027 Counters SHALL never wrap within a state.
REQ-028 Parameters SHALL satisfy 1 <= T0H < T1H < TBIT and TRESET >= 1; an invalid set SHALL be a synthesis/elaboration error.
REQ-029 valid and latch arriving together with the final cycle of LATCH SHALL not be accepted until ready=1 is visible.

Reset
REQ-030 While rst_n=0, asynchronously and regardless of state: led=0, ready=1, frame_done=0, state=IDLE, and bit index, cycle counter and shift register cleared.
REQ-031 Reset asserted mid-word or mid-latch SHALL abort the transfer immediately with led=0 and no frame_done pulse.
REQ-032 After rst_n deasserts, the first accepted word SHALL begin transmission as in REQ-016.

Verification
REQ-033 Accept data_in=24'h800000, latch=0 -> led high 16 and low 9 cycles, then 23 bits of high 8 and low 17; ready=1 at cycle 601 after acceptance; frame_done stays 0.
REQ-034 Accept data_in=24'hFFFFFF, latch=1 -> 24 bits of high 16 and low 9, then led=0 for 1000 cycles; frame_done pulses once; ready=1 on that same cycle.
REQ-035 Hold valid=1 with a new data_in throughout the transfer of REQ-033 -> no second capture until ready=1; the transmitted bits match only the first word.
REQ-036 Top-level style handshake: valid rises when ready=1 and drops when ready falls, over 140 words with latch on the last -> exactly 140*600 active cycles plus 1000 latch cycles, and one frame_done.
REQ-037 Pull rst_n low 5 cycles into the high phase of bit 10 -> led=0 in the same cycle, ready=1, no frame_done; after release a new word transmits correctly.
REQ-038 Elaborate with T0H=8, T1H=8 -> elaboration fails.

Source files
------------

// File: rtl/ws2812_serializer.sv
// WS2812 serializer: sends a 24-bit colour word MSB first as T0H/T1H-high, TBIT-long pulses, with an optional TRESET-low latch.
// Latency: led rises the cycle after acceptance; ready is high only in IDLE, and valid is ignored while busy.
module ws2812_serializer #(
    parameter int T0H    = 8,
    parameter int T1H    = 16,
    parameter int TBIT   = 25,
    parameter int TRESET = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
    output logic        ready,
    output logic        led,
    output logic        frame_done
);

    localparam int TMAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int CW   = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] T0H_M1    = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_M1    = CW'(T1H - 1);
    localparam logic [CW-1:0] TBIT_M1   = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRESET_M1 = CW'(TRESET - 1);

    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TRESET >= 1)) begin : g_bad_params
        $error("ws2812_serializer: need 1 <= T0H < T1H < TBIT and TRESET >= 1");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     bit_q, bit_d;
    logic [23:0]    shift_q, shift_d;
    logic           latch_q, latch_d;
    logic           led_q, led_d;
    logic           fd_q, fd_d;
    logic [CW-1:0]  high_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            latch_q <= 1'b0;
            led_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
            led_q   <= led_d;
            fd_q    <= fd_d;
        end
    end

    // The current bit always sits in shift_q[23]; cnt spans the whole bit so LOW ends at TBIT.
    assign high_m1 = shift_q[23] ? T1H_M1 : T0H_M1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        latch_d = latch_q;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    latch_d = latch;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == high_m1) state_d = LOW;
            end
            LOW: begin
                if (cnt_q == TBIT_M1) begin
                    cnt_d = '0;
                    if (bit_q == 5'd23) begin
                        state_d = latch_q ? LATCH : IDLE;
                    end else begin
                        state_d = HIGH;
                        bit_d   = bit_q + 5'd1;
                        shift_d = {shift_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LATCH: begin
                if (cnt_q == TRESET_M1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fd_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        led_d = (state_d == HIGH);
    end

    always_comb begin
        ready      = (state_q == IDLE);
        led        = led_q;
        frame_done = fd_q;
    end

endmodule
